// File: rtl/hex_2_ascii_tx_if.sv
// Purpose: groups the request side (start/value), the UART TX byte handshake and status flags.
// Latency: none; this is just wiring.
// Backpressure: tx_ready from the UART stalls tx_valid/tx_byte on the slave side.
interface hex_2_ascii_tx_if;
    logic        start_tick;
    logic [31:0] hex_value;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        busy;
    logic        done_tick;

    // Firmware/UART side: drives requests and ready, observes the byte stream
    modport master (
        output start_tick, hex_value, tx_ready,
        input  tx_valid, tx_byte, busy, done_tick
    );

    // Converter side
    modport slave (
        input  start_tick, hex_value, tx_ready,
        output tx_valid, tx_byte, busy, done_tick
    );
endinterface

// File: rtl/hex_2_ascii_tx.sv
// Purpose: serializes a captured 32-bit value as ASCII hex digits (MSB first), optional CR LF.
// Latency: first byte valid 1 cycle after an accepted start_tick; one byte per cycle when ready.
// Backpressure: tx_valid/tx_byte hold steady while tx_ready is low; start_tick ignored unless idle.
module hex_2_ascii_tx #(
    parameter int NUM_NIBBLES = 8,
    parameter bit APPEND_CRLF = 1'b1,
    parameter bit UPPERCASE   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    hex_2_ascii_tx_if.slave bus
);

    typedef enum logic [2:0] {IDLE, DIGIT, CR, LF, DONE} state_t;

    localparam logic [2:0] LAST_NIB = 3'(NUM_NIBBLES - 1);

    state_t      state;
    logic [31:0] value;
    logic [2:0]  cnt;
    logic        xfer;

    assign xfer = bus.tx_valid && bus.tx_ready;

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] v, input logic [2:0] idx);
        return v[{idx, 2'b00} +: 4];
    endfunction

    // Frame sequencer: all outputs registered, next byte loaded on the transfer edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            value         <= '0;
            cnt           <= '0;
            bus.tx_valid  <= 1'b0;
            bus.tx_byte   <= 8'h00;
            bus.busy      <= 1'b0;
            bus.done_tick <= 1'b0;
        end else begin
            bus.done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_tick) begin
                        value        <= bus.hex_value;
                        cnt          <= LAST_NIB;
                        bus.tx_byte  <= to_ascii(nib(bus.hex_value, LAST_NIB));
                        bus.tx_valid <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (xfer) begin
                        if (cnt == 3'd0) begin
                            if (APPEND_CRLF) begin
                                bus.tx_byte <= 8'h0D;
                                state       <= CR;
                            end else begin
                                bus.tx_valid  <= 1'b0;
                                bus.tx_byte   <= 8'h00;
                                bus.done_tick <= 1'b1;
                                state         <= DONE;
                            end
                        end else begin
                            cnt         <= cnt - 3'd1;
                            bus.tx_byte <= to_ascii(nib(value, cnt - 3'd1));
                        end
                    end
                end
                CR: begin
                    if (xfer) begin
                        bus.tx_byte <= 8'h0A;
                        state       <= LF;
                    end
                end
                LF: begin
                    if (xfer) begin
                        bus.tx_valid  <= 1'b0;
                        bus.tx_byte   <= 8'h00;
                        bus.done_tick <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    // start_tick in this cycle is deliberately not looked at
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.tx_valid <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_2_ascii_tx.sv
// Purpose: directed bench for hex_2_ascii_tx with a byte scoreboard per DUT instance.
// Latency: checks first-byte latency, back-to-back streaming and done_tick placement.
// Backpressure: random tx_ready stalls with hold checks on tx_valid/tx_byte.
module tb_hex_2_ascii_tx;

    logic clk;
    logic reset;

    hex_2_ascii_tx_if bus_a ();
    hex_2_ascii_tx_if bus_b ();

    hex_2_ascii_tx dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    hex_2_ascii_tx #(.NUM_NIBBLES(4), .APPEND_CRLF(1'b0), .UPPERCASE(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int xa = 0;
    int xb = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: builds the expected byte sequence for one frame
    task automatic push_frame(input bit to_b, input logic [31:0] v, input int n,
                              input bit crlf, input bit upper);
        string digs;
        digs = upper ? "0123456789ABCDEF" : "0123456789abcdef";
        for (int i = n - 1; i >= 0; i--) begin
            logic [3:0] d;
            logic [7:0] c;
            d = v[i*4 +: 4];
            c = digs.getc(int'(d));
            if (to_b) qb.push_back(c); else qa.push_back(c);
        end
        if (crlf) begin
            if (to_b) begin qb.push_back(8'h0D); qb.push_back(8'h0A); end
            else      begin qa.push_back(8'h0D); qa.push_back(8'h0A); end
        end
    endtask

    // Scoreboard and hold checker for the default instance
    bit         stall_a = 1'b0;
    logic [7:0] held_a;
    always @(negedge clk) begin
        if (!reset) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                check("hold_vld_a", {31'd0, bus_a.tx_valid}, 32'd1);
                check("hold_byte_a", {24'd0, bus_a.tx_byte}, {24'd0, held_a});
            end
            if (bus_a.tx_valid && bus_a.tx_ready) begin
                if (qa.size() == 0) begin
                    check("extra_byte_a", qa.size(), 1);
                end else begin
                    logic [7:0] e;
                    e = qa.pop_front();
                    check("byte_a", {24'd0, bus_a.tx_byte}, {24'd0, e});
                end
                xa++;
            end
            stall_a = bus_a.tx_valid && !bus_a.tx_ready;
            held_a  = bus_a.tx_byte;
        end
    end

    // Scoreboard for the 4-digit lowercase no-CRLF instance
    always @(negedge clk) begin
        if (reset && bus_b.tx_valid && bus_b.tx_ready) begin
            if (qb.size() == 0) begin
                check("extra_byte_b", qb.size(), 1);
            end else begin
                logic [7:0] e;
                e = qb.pop_front();
                check("byte_b", {24'd0, bus_b.tx_byte}, {24'd0, e});
            end
            xb++;
        end
    end

    task automatic wait_done(input bit use_b, input bit rnd, input bit chk_busy);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            seen = use_b ? bus_b.done_tick : bus_a.done_tick;
            if (!seen && chk_busy) check("busy_hold", {31'd0, bus_a.busy}, 32'd1);
            if (rnd) bus_a.tx_ready = 1'($urandom_range(0, 1));
        end
        bus_a.tx_ready = 1'b1;
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_xa(input int target);
        for (int i = 0; i < 100 && xa < target; i++) tick();
        check("xfer_count_reached", {31'd0, xa >= target}, 32'd1);
    endtask

    initial begin
        int base;
        reset = 1'b0;
        bus_a.start_tick = 1'b0; bus_a.hex_value = '0; bus_a.tx_ready = 1'b1;
        bus_b.start_tick = 1'b0; bus_b.hex_value = '0; bus_b.tx_ready = 1'b1;
        tick(); tick();
        check("rst_vld", {31'd0, bus_a.tx_valid}, 32'd0);
        check("rst_byte", {24'd0, bus_a.tx_byte}, 32'd0);
        check("rst_busy", {31'd0, bus_a.busy}, 32'd0);
        check("rst_done", {31'd0, bus_a.done_tick}, 32'd0);
        reset = 1'b1;
        tick();

        // 1: streaming at full rate, latency and done placement
        push_frame(0, 32'h1234ABCD, 8, 1, 1);
        bus_a.hex_value = 32'h1234ABCD; bus_a.start_tick = 1'b1;
        tick();
        bus_a.start_tick = 1'b0;
        check("t1_first_vld", {31'd0, bus_a.tx_valid}, 32'd1);
        check("t1_busy", {31'd0, bus_a.busy}, 32'd1);
        for (int i = 1; i < 10; i++) begin
            tick();
            check("t1_b2b_vld", {31'd0, bus_a.tx_valid}, 32'd1);
        end
        tick();
        check("t1_done", {31'd0, bus_a.done_tick}, 32'd1);
        check("t1_done_vld", {31'd0, bus_a.tx_valid}, 32'd0);
        tick();
        check("t1_done_pulse", {31'd0, bus_a.done_tick}, 32'd0);
        check("t1_busy_low", {31'd0, bus_a.busy}, 32'd0);
        check("t1_q_empty", qa.size(), 0);

        // 2: zeros under random backpressure
        push_frame(0, 32'h00000000, 8, 1, 1);
        bus_a.hex_value = 32'h0; bus_a.start_tick = 1'b1;
        bus_a.tx_ready = 1'($urandom_range(0, 1));
        tick();
        bus_a.start_tick = 1'b0;
        wait_done(0, 1, 0);
        tick();
        check("t2_q_empty", qa.size(), 0);

        // 3: 4 digits, lowercase, no CR/LF
        push_frame(1, 32'hFFFF0BEF, 4, 0, 0);
        bus_b.hex_value = 32'hFFFF0BEF; bus_b.start_tick = 1'b1;
        tick();
        bus_b.start_tick = 1'b0;
        wait_done(1, 0, 0);
        check("t3_count", xb, 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_no_crlf", {31'd0, bus_b.tx_valid}, 32'd0);
        end
        check("t3_q_empty", qb.size(), 0);

        // 4: start while busy is ignored
        push_frame(0, 32'hDEADBEEF, 8, 1, 1);
        base = xa;
        bus_a.hex_value = 32'hDEADBEEF; bus_a.start_tick = 1'b1;
        tick();
        bus_a.start_tick = 1'b0;
        wait_xa(base + 3);
        bus_a.hex_value = 32'h11111111; bus_a.start_tick = 1'b1;
        tick();
        bus_a.start_tick = 1'b0;
        wait_done(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_no_second", {31'd0, bus_a.tx_valid}, 32'd0);
        end
        check("t4_q_empty", qa.size(), 0);

        // 5: reset mid-frame abandons it
        push_frame(0, 32'hCAFEF00D, 8, 1, 1);
        base = xa;
        bus_a.hex_value = 32'hCAFEF00D; bus_a.start_tick = 1'b1;
        tick();
        bus_a.start_tick = 1'b0;
        wait_xa(base + 5);
        bus_a.tx_ready = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t5_vld", {31'd0, bus_a.tx_valid}, 32'd0);
        check("t5_busy", {31'd0, bus_a.busy}, 32'd0);
        check("t5_left", qa.size(), 5);
        qa.delete();
        bus_a.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_done", {31'd0, bus_a.done_tick}, 32'd0);
            check("t5_idle_vld", {31'd0, bus_a.tx_valid}, 32'd0);
        end
        push_frame(0, 32'h00000001, 8, 1, 1);
        bus_a.hex_value = 32'h00000001; bus_a.start_tick = 1'b1;
        tick();
        bus_a.start_tick = 1'b0;
        wait_done(0, 0, 1);
        tick();
        check("t5_q_empty", qa.size(), 0);

        // 6: start in DONE ignored, next cycle accepted
        push_frame(0, 32'h89ABCDEF, 8, 1, 1);
        bus_a.hex_value = 32'h89ABCDEF; bus_a.start_tick = 1'b1;
        tick();
        bus_a.start_tick = 1'b0;
        wait_done(0, 0, 0);
        bus_a.hex_value = 32'h11111111; bus_a.start_tick = 1'b1;
        tick();
        check("t6_ignored_vld", {31'd0, bus_a.tx_valid}, 32'd0);
        check("t6_ignored_busy", {31'd0, bus_a.busy}, 32'd0);
        push_frame(0, 32'h2468ACE0, 8, 1, 1);
        bus_a.hex_value = 32'h2468ACE0;
        tick();
        bus_a.start_tick = 1'b0;
        check("t6_accept_vld", {31'd0, bus_a.tx_valid}, 32'd1);
        check("t6_accept_busy", {31'd0, bus_a.busy}, 32'd1);
        wait_done(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_single_frame", {31'd0, bus_a.tx_valid}, 32'd0);
        end
        check("t6_q_empty", qa.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_2_ascii_tx.md
Name: hex_2_ascii_tx

Overview:
Converts a 32-bit register value into a stream of ASCII hex characters (MSB nibble first), optionally terminated by CR LF, and hands them one byte at a time to the UART transmitter over a valid/ready handshake. It is the transmit-side counterpart of the UART receive parse path: firmware writes a value and pulses start, and the block serializes the value as text to the host terminal. It sits between the SweRVolf memory-mapped register and the UART TX byte interface.

Parameters:
NUM_NIBBLES, 8, number of hex digits emitted (1..8); the lowest NUM_NIBBLES nibbles of hex_value are sent, most significant first.
APPEND_CRLF, 1, when 1, emit 0x0D then 0x0A after the last digit.
UPPERCASE, 1, when 1, digits A-F encode as 0x41-0x46; when 0, as 0x61-0x66.

Ports:
clk  input  1  system clock; all logic rising-edge.
reset  input  1  synchronous, active-low reset (reset==0 resets on the clk edge).
start_tick  input  1  one-cycle request to send hex_value; ignored unless idle.
hex_value  input  32  value to convert; sampled only on an accepted start_tick.
tx_ready  input  1  UART TX can accept a byte this cycle.
tx_valid  output  1  tx_byte holds a valid character.
tx_byte  output  8  ASCII character to transmit.
busy  output  1  high from the cycle after an accepted start until done_tick.
done_tick  output  1  one-cycle pulse after the final byte transfers.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; tx_valid=0, tx_byte=0x00, busy=0, done_tick=0; captured value and nibble counter cleared. Reset takes effect mid-frame: any partial frame is abandoned, no done_tick, and no further bytes are sent.
- States: IDLE, DIGIT, CR, LF, DONE.
- IDLE: on start_tick==1, latch hex_value into shift register, load nibble counter = NUM_NIBBLES-1, go to DIGIT. tx_valid rises on the next cycle (1-cycle latency from start_tick to the first valid byte).
- DIGIT: tx_byte = ASCII of the current nibble (nibble at position counter*4+3 : counter*4). Nibble 0-9 -> 0x30+n; 10-15 -> 0x41+(n-10) or 0x61+(n-10) per UPPERCASE. tx_valid=1.
- Transfer occurs on a cycle where tx_valid && tx_ready. On transfer in DIGIT: if counter==0, go to CR (APPEND_CRLF=1) or DONE (APPEND_CRLF=0); else decrement counter and present the next digit on the following cycle. Back-to-back transfers are allowed (one byte per cycle when tx_ready is held high).
- CR: tx_byte=0x0D, tx_valid=1; on transfer go to LF. LF: tx_byte=0x0A, tx_valid=1; on transfer go to DONE.
- DONE: tx_valid=0, done_tick=1 for exactly one cycle, busy=0 next, return to IDLE. A start_tick in the DONE cycle is ignored; one in the following IDLE cycle is accepted.
- Handshake rules: once tx_valid=1, tx_byte stays stable and tx_valid stays high until transfer; tx_valid never drops without a transfer except on reset. tx_ready while tx_valid=0 has no effect.
- start_tick while busy: ignored; the captured value is unchanged.
- hex_value changes after capture have no effect on the frame in flight.
- Frame length: NUM_NIBBLES + 2*APPEND_CRLF bytes.

Test Plan:
- Default params, hex_value=0x1234ABCD, start_tick pulse, tx_ready held 1 -> bytes 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44,0x0D,0x0A on 10 consecutive cycles, first valid 1 cycle after start; done_tick 1 cycle after 0x0A transfers.
- hex_value=0x00000000 with random tx_ready backpressure (~50% duty) -> eight 0x30 then 0x0D,0x0A; tx_byte stable and tx_valid high during every stall; no byte lost or duplicated.
- UPPERCASE=0, APPEND_CRLF=0, NUM_NIBBLES=4, hex_value=0xFFFF0BEF -> 0x30,0x62,0x65,0x66, then done_tick; no CR/LF emitted.
- Start 0xDEADBEEF, pulse start_tick with 0x11111111 after the 3rd byte -> full "DEADBEEF\r\n" sent; second request ignored; busy stays high throughout.
- Reset (reset=0 for 1 cycle) after the 5th byte of 0xCAFEF00D -> next cycle tx_valid=0, busy=0, no done_tick; new start with 0x00000001 -> "00000001\r\n" sent cleanly.
- start_tick in the DONE cycle and again 1 cycle later -> first ignored, second accepted; exactly one new frame follows.
